// File: rtl/bconv_multi_kernel_engine.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | bconv_multi_kernel_engine: binary 3x3 XNOR/popcount conv, NUM_K kernels/img  |
// | Optional macro: BCONV_RUNTIME_THRESH_EN (per-kernel threshold, weight[12:9]) |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module bconv_multi_kernel_engine #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter int                NUM_K    = 2,
    parameter int                W_BASE   = 0,
    parameter logic [ADDR_W-1:0] OUT_BASE = 'h200,
    parameter int                THRESH   = 5
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);
    localparam int NW = $clog2(DATA_W + 1);
    localparam int KW = (NUM_K > 1) ? $clog2(NUM_K) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_HDR_A, S_HDR, S_FILL, S_OUT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NW-1:0]     n_q, n_d, row_q, row_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d, rd_addr_q, rd_addr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] wa_q, wa_d, wm_addr_q, wm_addr_d, rd_next;
    logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, wd_q, wd_d, out_bits;
    logic              we_q, we_d, busy_q, busy_d, err_q, err_d;
    logic [8:0]        weight_q [NUM_K];
    logic [8:0]        weight_d [NUM_K];
    logic [3:0]        thr_q [NUM_K];
    logic [3:0]        thr_d [NUM_K];
    logic [8:0]        w_cur;
    logic [3:0]        thr_cur, thr_eff;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    always_comb begin
        w_cur   = '0;
        thr_cur = '0;
        for (int i = 0; i < NUM_K; i++) begin
            if (k_q == KW'(i)) begin
                w_cur   = weight_q[i];
                thr_cur = thr_q[i];
            end
        end
`ifdef BCONV_RUNTIME_THRESH_EN
        // Zero selects the build-time threshold; >9 can never be reached by a 9-bit popcount.
        thr_eff = (thr_cur == 4'd0) ? 4'(THRESH) : thr_cur;
`else
        thr_eff = 4'(THRESH);
`endif
    end

`ifdef BCONV_RUNTIME_THRESH_EN
    logic unused_wbits;
    assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:13];
`else
    logic unused_wbits;
    assign unused_wbits = ^{wmem_dut_read_data[DATA_W-1:9], thr_cur};
`endif

    generate
        for (genvar j = 0; j < DATA_W - 2; j++) begin : g_pe
            logic [8:0] win;
            assign win         = {r2_q[j+2:j], r1_q[j+2:j], r0_q[j+2:j]};
            assign out_bits[j] = (popcount9(~(win ^ w_cur)) >= thr_eff) && (NW'(j + 2) < n_q);
        end
    endgenerate
    assign out_bits[DATA_W-1:DATA_W-2] = '0;

    // Reads stop at the word after the image (next header), never beyond it.
    assign rd_next = (rd_addr_q == base_q + ADDR_W'(n_q)) ? rd_addr_q : rd_addr_q + 1'b1;

    always_comb begin
        state_d   = state_q;   cnt_d    = cnt_q;    n_d     = n_q;     row_d  = row_q;
        k_d       = k_q;       base_d   = base_q;   rd_addr_d = rd_addr_q;
        wr_ptr_d  = wr_ptr_q;  wa_d     = wa_q;     wm_addr_d = wm_addr_q;
        r0_d      = r0_q;      r1_d     = r1_q;     r2_d    = r2_q;    wd_d   = wd_q;
        we_d      = 1'b0;      err_d    = err_q;
        weight_d  = weight_q;  thr_d    = thr_q;
        case (state_q)
            S_IDLE: if (dut_run) begin
                state_d   = S_LOAD_W;
                cnt_d     = '0;
                wm_addr_d = ADDR_W'(W_BASE);
                rd_addr_d = '0;
                wr_ptr_d  = OUT_BASE;
                err_d     = 1'b0;
            end
            S_LOAD_W: begin
                wm_addr_d = wm_addr_q + 1'b1;
                cnt_d     = cnt_q + 4'd1;
                for (int i = 0; i < NUM_K; i++) begin
                    if (cnt_q == 4'(i + 1)) begin
                        weight_d[i] = wmem_dut_read_data[8:0];
                        thr_d[i]    = wmem_dut_read_data[12:9];
                    end
                end
                if (cnt_q == 4'(NUM_K)) begin
                    state_d   = S_HDR_A;
                    wm_addr_d = ADDR_W'(W_BASE);
                end
            end
            S_HDR_A: state_d = S_HDR;
            S_HDR: begin
                if (&sram_dut_read_data) begin
                    state_d = S_DONE;
                end else if (sram_dut_read_data < DATA_W'(3) ||
                             sram_dut_read_data > DATA_W'(DATA_W)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    n_d       = sram_dut_read_data[NW-1:0];
                    base_d    = rd_addr_q + 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    k_d       = '0;
                    cnt_d     = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                rd_addr_d = rd_next;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q != 4'd0) begin
                    r0_d = r1_q; r1_d = r2_q; r2_d = sram_dut_read_data;
                end
                if (cnt_q == 4'd3) begin
                    state_d = S_OUT;
                    row_d   = '0;
                end
            end
            S_OUT: begin
                rd_addr_d = rd_next;
                r0_d = r1_q; r1_d = r2_q; r2_d = sram_dut_read_data;
                we_d     = 1'b1;
                wa_d     = wr_ptr_q;
                wd_d     = out_bits;
                wr_ptr_d = wr_ptr_q + 1'b1;
                row_d    = row_q + 1'b1;
                if (row_q == n_q - NW'(3)) begin
                    if (k_q != KW'(NUM_K - 1)) begin
                        k_d       = k_q + 1'b1;
                        rd_addr_d = base_q;
                        cnt_d     = '0;
                        state_d   = S_FILL;
                    end else begin
                        rd_addr_d = base_q + ADDR_W'(n_q);
                        state_d   = S_HDR_A;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= S_IDLE;  cnt_q <= '0;  n_q <= '0;  row_q <= '0;  k_q <= '0;
            base_q  <= '0;  rd_addr_q <= '0;  wr_ptr_q <= '0;  wa_q <= '0;
            wm_addr_q <= ADDR_W'(W_BASE);
            r0_q <= '0;  r1_q <= '0;  r2_q <= '0;  wd_q <= '0;
            we_q <= 1'b0;  busy_q <= 1'b0;  err_q <= 1'b0;
            for (int i = 0; i < NUM_K; i++) begin
                weight_q[i] <= '0;
                thr_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  n_q <= n_d;  row_q <= row_d;  k_q <= k_d;
            base_q  <= base_d;  rd_addr_q <= rd_addr_d;  wr_ptr_q <= wr_ptr_d;  wa_q <= wa_d;
            wm_addr_q <= wm_addr_d;
            r0_q <= r0_d;  r1_q <= r1_d;  r2_q <= r2_d;  wd_q <= wd_d;
            we_q <= we_d;  busy_q <= busy_d;  err_q <= err_d;
            weight_q <= weight_d;
            thr_q    <= thr_d;
        end
    end

    assign dut_busy               = busy_q;
    assign dut_error              = err_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wa_q;
    assign dut_sram_write_data    = wd_q;
    assign dut_sram_write_enable  = we_q;
    assign dut_wmem_read_address  = wm_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_bconv_multi_kernel_engine.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_bconv_multi_kernel_engine: scoreboard bench with a per-window pixel model |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_bconv_multi_kernel_engine;
    localparam int          DATA_W   = 16;
    localparam int          ADDR_W   = 12;
    localparam int          NUM_K    = 2;
    localparam int          THRESH   = 5;
    localparam logic [11:0] OUT_BASE = 12'h200;

    logic        clk = 1'b0;
    logic        reset_b, dut_run;
    logic        dut_busy, dut_error, dut_sram_write_enable;
    logic [11:0] dut_sram_read_address, dut_sram_write_address, dut_wmem_read_address;
    logic [15:0] sram_dut_read_data, dut_sram_write_data, wmem_dut_read_data;

    logic [15:0] mem  [0:4095];
    logic [15:0] wmem [0:4095];
    int          img_n [0:2];
    logic [15:0] img_rows [0:2][0:15];

    typedef struct { int addr; int data; int gap; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0, n_pass = 0, cyc = 0, last_wr_cyc = 0, wr_count = 0;
    int   max_rd = 0, term_addr = 0;

    bconv_multi_kernel_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_K(NUM_K), .W_BASE(0),
        .OUT_BASE(OUT_BASE), .THRESH(THRESH)
    ) dut (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run),
        .dut_busy(dut_busy), .dut_error(dut_error),
        .dut_sram_read_address(dut_sram_read_address),
        .sram_dut_read_data(sram_dut_read_data),
        .dut_sram_write_address(dut_sram_write_address),
        .dut_sram_write_data(dut_sram_write_data),
        .dut_sram_write_enable(dut_sram_write_enable),
        .dut_wmem_read_address(dut_wmem_read_address),
        .wmem_dut_read_data(wmem_dut_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sram_dut_read_data <= mem[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    // Highest read address presented during a run; cleared when a run is launched.
    always @(posedge clk) begin
        if (dut_run && !dut_busy) max_rd <= 0;
        else if (dut_busy && int'(dut_sram_read_address) > max_rd) max_rd <= int'(dut_sram_read_address);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_b && dut_sram_write_enable) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", int'(dut_sram_write_address), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", int'(dut_sram_write_address), mon_e.addr);
                chk("write_data", int'(dut_sram_write_data), mon_e.data);
                if (mon_e.gap != 0) chk("write_gap", cyc - last_wr_cyc, mon_e.gap);
            end
            last_wr_cyc = cyc;
        end
    end

    // Reference: count matching pixels in each 3x3 window directly from the image rows.
    function automatic int exp_word(input int i, input int k, input int r);
        logic [15:0] w;
        int thr, cnt, word;
        w   = wmem[k];
        thr = THRESH;
`ifdef BCONV_RUNTIME_THRESH_EN
        if (w[12:9] != 4'd0) thr = int'(w[12:9]);
`endif
        word = 0;
        for (int j = 0; j < img_n[i] - 2; j++) begin
            cnt = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    if (img_rows[i][r+dr][j+dc] == w[dr*3+dc]) cnt++;
            if (cnt >= thr) word = word | (1 << j);
        end
        return word;
    endfunction

    task automatic prepare_job(input int nimg, input logic [15:0] tail);
        int a, wa;
        exp_t e;
        a  = 0;
        wa = int'(OUT_BASE);
        for (int i = 0; i < nimg; i++) begin
            mem[a] = 16'(img_n[i]); a++;
            for (int r = 0; r < img_n[i]; r++) begin mem[a] = img_rows[i][r]; a++; end
        end
        mem[a]    = tail;
        term_addr = a;
        for (int i = 0; i < nimg; i++)
            for (int k = 0; k < NUM_K; k++)
                for (int r = 0; r <= img_n[i] - 3; r++) begin
                    e.addr = wa % 4096;
                    e.data = exp_word(i, k, r);
                    e.gap  = (r != 0) ? 1 : ((k != 0) ? 5 : 0);
                    exp_q.push_back(e);
                    wa++;
                end
    endtask

    task automatic run_job(input int exp_err);
        int t;
        dut_run = 1'b1; @(negedge clk); dut_run = 1'b0;
        t = 0;
        while (!dut_busy && t < 10) begin @(negedge clk); t++; end
        chk("busy_rise", int'(dut_busy), 1);
        chk("error_cleared_on_run", int'(dut_error), 0);
        dut_run = 1'b1; @(negedge clk); dut_run = 1'b0;
        t = 0;
        while (dut_busy && t < 5000) begin @(negedge clk); t++; end
        chk("busy_fall", int'(dut_busy), 0);
        chk("pending_writes", exp_q.size(), 0);
        chk("error_flag", int'(dut_error), exp_err);
        chk("max_read_addr", max_rd, term_addr);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t, snap, nimg;
        for (int a = 0; a < 4096; a++) begin mem[a] = 16'hFFFF; wmem[a] = 16'h0000; end
        reset_b = 1'b0; dut_run = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(dut_busy), 0);
        chk("reset_error", int'(dut_error), 0);
        chk("reset_we", int'(dut_sram_write_enable), 0);
        chk("reset_rd_addr", int'(dut_sram_read_address), 0);
        chk("reset_wr_addr", int'(dut_sram_write_address), 0);
        chk("reset_wr_data", int'(dut_sram_write_data), 0);
        chk("reset_wm_addr", int'(dut_wmem_read_address), 0);
        reset_b = 1'b1;
        @(negedge clk);

        // N=10, all-ones rows, all-ones kernels
        wmem[0] = 16'h01FF; wmem[1] = 16'h01FF;
        img_n[0] = 10;
        for (int r = 0; r < 16; r++) img_rows[0][r] = 16'h03FF;
        prepare_job(1, 16'hFFFF); run_job(0);

        // N=16 blank image, kernels 000 / 1FF
        wmem[0] = 16'h0000; wmem[1] = 16'h01FF;
        img_n[0] = 16;
        for (int r = 0; r < 16; r++) img_rows[0][r] = 16'h0000;
        prepare_job(1, 16'hFFFF); run_job(0);

        // Two images N=3 and N=12 back to back
        wmem[0] = 16'($urandom); wmem[1] = 16'($urandom);
        img_n[0] = 3; img_n[1] = 12;
        for (int r = 0; r < 16; r++) begin img_rows[0][r] = 16'($urandom); img_rows[1][r] = 16'($urandom); end
        prepare_job(2, 16'hFFFF); run_job(0);

        // Exactly one mismatching pixel in every window; kernel 0 carries threshold field 9
        wmem[0] = 16'h13FF; wmem[1] = 16'h01FF;
        img_n[0] = 5;
        for (int r = 0; r < 16; r++) img_rows[0][r] = 16'h001F;
        img_rows[0][2] = 16'h001B;
        prepare_job(1, 16'hFFFF); run_job(0);

        // Terminator only
        prepare_job(0, 16'hFFFF); run_job(0);

        // Illegal headers: too small, too large after a valid image, zero
        prepare_job(0, 16'h0002); run_job(1);
        img_n[0] = 4;
        for (int r = 0; r < 16; r++) img_rows[0][r] = 16'($urandom);
        prepare_job(1, 16'h0011); run_job(1);
        prepare_job(0, 16'h0000); run_job(1);

        // Randomised images and kernels
        for (int n = 0; n < 6; n++) begin
            nimg = int'($urandom_range(1, 3));
            wmem[0] = 16'($urandom); wmem[1] = 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                img_n[i] = int'($urandom_range(3, 16));
                for (int r = 0; r < 16; r++) img_rows[i][r] = 16'($urandom);
            end
            prepare_job(nimg, 16'hFFFF); run_job(0);
        end

        // Reset in the middle of the output phase
        img_n[0] = 16;
        for (int r = 0; r < 16; r++) img_rows[0][r] = 16'($urandom);
        prepare_job(1, 16'hFFFF);
        dut_run = 1'b1; @(negedge clk); dut_run = 1'b0;
        t = 0;
        while (!dut_sram_write_enable && t < 100) begin @(negedge clk); t++; end
        chk("write_seen_before_reset", int'(dut_sram_write_enable), 1);
        repeat (4) @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        chk("midrun_reset_busy", int'(dut_busy), 0);
        chk("midrun_reset_we", int'(dut_sram_write_enable), 0);
        chk("midrun_reset_rd_addr", int'(dut_sram_read_address), 0);
        chk("midrun_reset_wr_addr", int'(dut_sram_write_address), 0);
        chk("midrun_reset_wm_addr", int'(dut_wmem_read_address), 0);
        exp_q.delete();
        snap = wr_count;
        reset_b = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_writes_after_reset", wr_count - snap, 0);
        chk("idle_after_reset", int'(dut_busy), 0);

        // Engine still works after the abort
        prepare_job(1, 16'hFFFF); run_job(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
